// File: rtl/hbm_port_gate.sv
// Address-phase gate for one HBM pseudo-channel: holds AR/AW until calibration settles, caps in-flight work, throttles when hot, drains and halts on thermal trip.
// Zero added latency (gating is combinational from registered state); upstream sees ready=0 whenever the gate is closed.
module hbm_port_gate #(
    parameter int          MAX_OUTSTANDING = 8,
    parameter int          INIT_DELAY      = 16,
    parameter logic [6:0]  TEMP_HI         = 7'd85,
    parameter logic [6:0]  TEMP_LO         = 7'd80,
    parameter int          THROTTLE_GAP    = 4,
    localparam int         CW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          apb_complete_i,
    input  logic          cattrip_i,
    input  logic [6:0]    temp_i,
    input  logic          slv_ar_valid_i,
    output logic          slv_ar_ready_o,
    output logic          mst_ar_valid_o,
    input  logic          mst_ar_ready_i,
    input  logic          slv_aw_valid_i,
    output logic          slv_aw_ready_o,
    output logic          mst_aw_valid_o,
    input  logic          mst_aw_ready_i,
    input  logic          r_valid_i,
    input  logic          r_ready_i,
    input  logic          r_last_i,
    input  logic          b_valid_i,
    input  logic          b_ready_i,
    output logic          hbm_ready_o,
    output logic          throttle_o,
    output logic          halted_o,
    output logic          err_o,
    output logic [CW-1:0] rd_outstanding_o,
    output logic [CW-1:0] wr_outstanding_o
);

    localparam int DW = $clog2(INIT_DELAY + 1);
    localparam int GW = $clog2(THROTTLE_GAP + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        S_INIT,
        S_SETTLE,
        S_RUN,
        S_THROTTLE,
        S_DRAIN,
        S_HALT
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_delay;
    logic [GW-1:0] r_gap;
    logic [CW-1:0] r_rd_cnt;
    logic [CW-1:0] r_wr_cnt;
    logic          r_err;

    logic w_active;
    logic w_allow_ar;
    logic w_allow_aw;
    logic w_ar_hs;
    logic w_aw_hs;
    logic w_rd_done;
    logic w_wr_done;
    logic w_rd_uf;
    logic w_wr_uf;
    logic w_thr_exit;

    assign w_active   = (r_state == S_RUN) || (r_state == S_THROTTLE);
    assign w_allow_ar = w_active && (r_rd_cnt < MAX_C) && (r_gap == '0);
    assign w_allow_aw = w_active && (r_wr_cnt < MAX_C) && (r_gap == '0);

    assign mst_ar_valid_o = slv_ar_valid_i & w_allow_ar;
    assign slv_ar_ready_o = mst_ar_ready_i & w_allow_ar;
    assign mst_aw_valid_o = slv_aw_valid_i & w_allow_aw;
    assign slv_aw_ready_o = mst_aw_ready_i & w_allow_aw;

    assign w_ar_hs   = slv_ar_valid_i & mst_ar_ready_i & w_allow_ar;
    assign w_aw_hs   = slv_aw_valid_i & mst_aw_ready_i & w_allow_aw;
    assign w_rd_done = r_valid_i & r_ready_i & r_last_i;
    assign w_wr_done = b_valid_i & b_ready_i;

    // A completion with nothing in flight (and no same-cycle issue to cancel it) is an underflow.
    assign w_rd_uf = w_rd_done & ~w_ar_hs & (r_rd_cnt == '0);
    assign w_wr_uf = w_wr_done & ~w_aw_hs & (r_wr_cnt == '0);

    assign w_thr_exit = (r_state == S_THROTTLE) && !cattrip_i && (temp_i < TEMP_LO);

    assign hbm_ready_o      = w_active;
    assign throttle_o       = (r_state == S_THROTTLE);
    assign halted_o         = (r_state == S_HALT);
    assign err_o            = r_err;
    assign rd_outstanding_o = r_rd_cnt;
    assign wr_outstanding_o = r_wr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
            r_delay <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (cattrip_i) begin
                        r_state <= S_HALT;
                    end else if (apb_complete_i) begin
                        r_delay <= DW'(INIT_DELAY - 1);
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cattrip_i) begin
                        r_state <= S_HALT;
                    end else if (r_delay == '0) begin
                        r_state <= S_RUN;
                    end else begin
                        r_delay <= r_delay - DW'(1);
                    end
                end
                S_RUN: begin
                    if (cattrip_i) begin
                        r_state <= S_DRAIN;
                    end else if (temp_i >= TEMP_HI) begin
                        r_state <= S_THROTTLE;
                    end
                end
                S_THROTTLE: begin
                    if (cattrip_i) begin
                        r_state <= S_DRAIN;
                    end else if (temp_i < TEMP_LO) begin
                        r_state <= S_RUN;
                    end
                end
                S_DRAIN: begin
                    if ((r_rd_cnt == '0) && (r_wr_cnt == '0)) begin
                        r_state <= S_HALT;
                    end
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_INIT;
            endcase
        end
    end

    // Leaving THROTTLE wins over a reload so RUN resumes back-to-back issue immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap <= '0;
        end else if (w_thr_exit) begin
            r_gap <= '0;
        end else if ((r_state == S_THROTTLE) && (w_ar_hs || w_aw_hs)) begin
            r_gap <= GW'(THROTTLE_GAP);
        end else if (r_gap != '0) begin
            r_gap <= r_gap - GW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_ar_hs && !w_rd_done) begin
                r_rd_cnt <= r_rd_cnt + CW'(1);
            end else if (!w_ar_hs && w_rd_done && (r_rd_cnt != '0)) begin
                r_rd_cnt <= r_rd_cnt - CW'(1);
            end
            if (w_aw_hs && !w_wr_done) begin
                r_wr_cnt <= r_wr_cnt + CW'(1);
            end else if (!w_aw_hs && w_wr_done && (r_wr_cnt != '0)) begin
                r_wr_cnt <= r_wr_cnt - CW'(1);
            end
            if (w_rd_uf || w_wr_uf) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hbm_port_gate.sv
// Bench for hbm_port_gate: directed phases with randomized traffic, checked every cycle against a cycle-count based reference model.
module tb_hbm_port_gate;

    localparam int         MAXO = 8;
    localparam int         IDLY = 16;
    localparam int         GAP  = 4;
    localparam logic [6:0] THI  = 7'd85;
    localparam logic [6:0] TLO  = 7'd80;
    localparam int         CW   = $clog2(MAXO + 1);

    localparam int P_INIT = 0, P_SETTLE = 1, P_RUN = 2, P_THR = 3, P_DRAIN = 4, P_HALT = 5;

    logic          clk;
    logic          rst_n;
    logic          apb_complete_i, cattrip_i;
    logic [6:0]    temp_i;
    logic          slv_ar_valid_i, slv_ar_ready_o, mst_ar_valid_o, mst_ar_ready_i;
    logic          slv_aw_valid_i, slv_aw_ready_o, mst_aw_valid_o, mst_aw_ready_i;
    logic          r_valid_i, r_ready_i, r_last_i, b_valid_i, b_ready_i;
    logic          hbm_ready_o, throttle_o, halted_o, err_o;
    logic [CW-1:0] rd_outstanding_o, wr_outstanding_o;

    hbm_port_gate #(
        .MAX_OUTSTANDING(MAXO), .INIT_DELAY(IDLY), .TEMP_HI(THI), .TEMP_LO(TLO), .THROTTLE_GAP(GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .apb_complete_i(apb_complete_i), .cattrip_i(cattrip_i), .temp_i(temp_i),
        .slv_ar_valid_i(slv_ar_valid_i), .slv_ar_ready_o(slv_ar_ready_o),
        .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_ready_i(mst_ar_ready_i),
        .slv_aw_valid_i(slv_aw_valid_i), .slv_aw_ready_o(slv_aw_ready_o),
        .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_ready_i(mst_aw_ready_i),
        .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i),
        .b_valid_i(b_valid_i), .b_ready_i(b_ready_i),
        .hbm_ready_o(hbm_ready_o), .throttle_o(throttle_o), .halted_o(halted_o), .err_o(err_o),
        .rd_outstanding_o(rd_outstanding_o), .wr_outstanding_o(wr_outstanding_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase, in-flight counts, sticky error, and absolute cycle numbers for
    // "traffic opens at" and "next throttled issue allowed at".
    int ph, m_rd, m_wr, m_err, cyc, run_at, gap_free;
    int n_checks = 0;
    int n_err    = 0;
    int hs, entry;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ph = P_INIT; m_rd = 0; m_wr = 0; m_err = 0; cyc = 0; run_at = 0; gap_free = 0;
    endtask

    function automatic bit m_allow(input int cnt);
        return (ph == P_RUN || ph == P_THR) && (cnt < MAXO) && (cyc >= gap_free);
    endfunction

    task automatic model_update(input bit aa, input bit aw);
        int c, arh, awh, rdn, bdn, pre_rd, pre_wr, nph;
        bit thr_exit;
        c      = cyc + 1;
        arh    = (slv_ar_valid_i && mst_ar_ready_i && aa) ? 1 : 0;
        awh    = (slv_aw_valid_i && mst_aw_ready_i && aw) ? 1 : 0;
        rdn    = (r_valid_i && r_ready_i && r_last_i) ? 1 : 0;
        bdn    = (b_valid_i && b_ready_i) ? 1 : 0;
        pre_rd = m_rd;
        pre_wr = m_wr;
        m_rd = m_rd + arh - rdn;
        if (m_rd < 0) begin m_rd = 0; m_err = 1; end
        m_wr = m_wr + awh - bdn;
        if (m_wr < 0) begin m_wr = 0; m_err = 1; end
        thr_exit = (ph == P_THR) && !cattrip_i && (temp_i < TLO);
        nph = ph;
        case (ph)
            P_INIT:   if (cattrip_i) nph = P_HALT;
                      else if (apb_complete_i) begin nph = P_SETTLE; run_at = c + IDLY; end
            P_SETTLE: if (cattrip_i) nph = P_HALT; else if (c == run_at) nph = P_RUN;
            P_RUN:    if (cattrip_i) nph = P_DRAIN; else if (temp_i >= THI) nph = P_THR;
            P_THR:    if (cattrip_i) nph = P_DRAIN; else if (temp_i < TLO) nph = P_RUN;
            P_DRAIN:  if (pre_rd == 0 && pre_wr == 0) nph = P_HALT;
            default:  nph = ph;
        endcase
        if (thr_exit) gap_free = 0;
        else if (ph == P_THR && (arh + awh) > 0) gap_free = c + GAP;
        ph  = nph;
        cyc = c;
    endtask

    // Called just after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        bit aa, aw;
        #1;
        aa = m_allow(m_rd);
        aw = m_allow(m_wr);
        chk("mst_ar_valid", mst_ar_valid_o, slv_ar_valid_i & aa);
        chk("slv_ar_ready", slv_ar_ready_o, mst_ar_ready_i & aa);
        chk("mst_aw_valid", mst_aw_valid_o, slv_aw_valid_i & aw);
        chk("slv_aw_ready", slv_aw_ready_o, mst_aw_ready_i & aw);
        chk("hbm_ready", hbm_ready_o, (ph == P_RUN || ph == P_THR));
        chk("throttle", throttle_o, (ph == P_THR));
        chk("halted", halted_o, (ph == P_HALT));
        chk("err", err_o, m_err[0]);
        chk("rd_outstanding", 8'(rd_outstanding_o), 8'(m_rd));
        chk("wr_outstanding", 8'(wr_outstanding_o), 8'(m_wr));
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_update(aa, aw);
        @(negedge clk);
    endtask

    task automatic clear_traffic();
        slv_ar_valid_i = 0; mst_ar_ready_i = 1; slv_aw_valid_i = 0; mst_aw_ready_i = 1;
        r_valid_i = 0; r_ready_i = 0; r_last_i = 0; b_valid_i = 0; b_ready_i = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1 model_reset();
        step();
        rst_n = 1;
    endtask

    task automatic drain_all();
        clear_traffic();
        for (int k = 0; k < 20 && (m_rd > 0 || m_wr > 0); k++) begin
            r_valid_i = (m_rd > 0); r_ready_i = 1; r_last_i = 1;
            b_valid_i = (m_wr > 0); b_ready_i = 1;
            step();
        end
        clear_traffic();
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 40 && hbm_ready_o !== 1'b1; k++) step();
    endtask

    initial begin
        rst_n = 0; apb_complete_i = 0; cattrip_i = 0; temp_i = 7'd40;
        clear_traffic();
        model_reset();
        @(negedge clk);
        do_reset();

        // Calibration: upstream AR waits from the start, calibration reported at cycle 10.
        slv_ar_valid_i = 1;
        for (int k = 0; k < 10; k++) step();
        apb_complete_i = 1;
        step();
        entry = cyc;
        wait_ready();
        chk("init_latency", 8'(cyc - entry), 8'(IDLY));
        #1 chk("first_ar_hs", mst_ar_valid_o & mst_ar_ready_i, 1'b1);
        apb_complete_i = 0;

        // Outstanding cap: ten cycles of AR with no read data.
        for (int k = 0; k < 9; k++) step();
        chk("cap_count", 8'(rd_outstanding_o), 8'(MAXO));
        #1 chk("cap_ready", slv_ar_ready_o, 1'b0);
        step();
        r_valid_i = 1; r_ready_i = 1; r_last_i = 1;
        step();
        chk("cap_release", 8'(rd_outstanding_o), 8'(MAXO - 1));
        r_valid_i = 0;
        step();
        chk("cap_refill", 8'(rd_outstanding_o), 8'(MAXO));

        // Issue and completion in one cycle, then a write response with nothing in flight.
        slv_ar_valid_i = 0; r_valid_i = 1;
        step();
        slv_ar_valid_i = 1;
        step();
        chk("simul_rd", 8'(rd_outstanding_o), 8'(MAXO - 1));
        clear_traffic();
        b_valid_i = 1; b_ready_i = 1;
        step();
        chk("uf_wr_cnt", 8'(wr_outstanding_o), 8'd0);
        chk("uf_err", err_o, 1'b1);
        b_valid_i = 0;
        step();
        chk("err_sticky", err_o, 1'b1);

        // Randomized traffic with temperature wandering around the thresholds.
        for (int k = 0; k < 60; k++) begin
            slv_ar_valid_i = 1'($urandom_range(0, 1)); mst_ar_ready_i = 1'($urandom_range(0, 1));
            slv_aw_valid_i = 1'($urandom_range(0, 1)); mst_aw_ready_i = 1'($urandom_range(0, 1));
            r_valid_i = 1'($urandom_range(0, 1)); r_ready_i = 1'($urandom_range(0, 1));
            r_last_i  = 1'($urandom_range(0, 1));
            b_valid_i = 1'($urandom_range(0, 1)); b_ready_i = 1'($urandom_range(0, 1));
            temp_i    = 7'($urandom_range(74, 90));
            step();
        end
        temp_i = 7'd40;
        drain_all();
        step();

        // Throttle hysteresis.
        temp_i = THI;
        step();
        chk("thr_enter", throttle_o, 1'b1);
        slv_ar_valid_i = 1;
        hs = 0;
        for (int k = 0; k < 20; k++) begin
            #1 if (mst_ar_valid_o && mst_ar_ready_i) hs++;
            step();
        end
        chk("thr_spacing", 8'(hs), 8'(20 / (GAP + 1)));
        temp_i = 7'd82;
        for (int k = 0; k < 10; k++) step();
        chk("thr_hyst", throttle_o, 1'b1);
        drain_all();
        temp_i = 7'd79;
        step();
        chk("thr_exit", throttle_o, 1'b0);
        slv_ar_valid_i = 1;
        hs = 0;
        for (int k = 0; k < 5; k++) begin
            #1 if (mst_ar_valid_o && mst_ar_ready_i) hs++;
            step();
        end
        chk("run_b2b", 8'(hs), 8'd5);
        temp_i = 7'd40;
        drain_all();

        // Thermal trip with 3 reads and 2 writes in flight.
        slv_ar_valid_i = 1; slv_aw_valid_i = 1;
        step(); step();
        slv_aw_valid_i = 0;
        step();
        chk("trip_rd_setup", 8'(rd_outstanding_o), 8'd3);
        chk("trip_wr_setup", 8'(wr_outstanding_o), 8'd2);
        clear_traffic();
        cattrip_i = 1;
        step();
        slv_ar_valid_i = 1; slv_aw_valid_i = 1;
        hs = 0;
        for (int k = 0; k < 3; k++) begin
            #1 if ((mst_ar_valid_o && mst_ar_ready_i) || (mst_aw_valid_o && mst_aw_ready_i)) hs++;
            step();
        end
        chk("drain_blocks", 8'(hs), 8'd0);
        r_valid_i = 1; r_ready_i = 1; r_last_i = 1; b_valid_i = 1; b_ready_i = 1;
        step(); step();
        b_valid_i = 0;
        step();
        r_valid_i = 0;
        chk("drain_not_halted", halted_o, 1'b0);
        step();
        chk("drain_halted", halted_o, 1'b1);
        cattrip_i = 0;
        for (int k = 0; k < 3; k++) step();
        chk("halt_terminal", halted_o, 1'b1);

        // Reset while draining, then a second calibration sequence.
        clear_traffic();
        do_reset();
        apb_complete_i = 1;
        wait_ready();
        apb_complete_i = 0;
        b_valid_i = 1; b_ready_i = 1;
        step();
        clear_traffic();
        slv_ar_valid_i = 1;
        step(); step();
        slv_ar_valid_i = 0; cattrip_i = 1;
        step();
        step();
        do_reset();
        cattrip_i = 0;
        chk("rst_rd", 8'(rd_outstanding_o), 8'd0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_halted", halted_o, 1'b0);
        slv_ar_valid_i = 1;
        for (int k = 0; k < 5; k++) step();
        #1 chk("rst_gate_closed", mst_ar_valid_o, 1'b0);
        apb_complete_i = 1;
        step();
        entry = cyc;
        wait_ready();
        chk("reinit_latency", 8'(cyc - entry), 8'(IDLY));
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/hbm_port_gate.md
Name: hbm_port_gate

Overview:
- Per-pseudo-channel traffic controller between the AXI crossbar master port and one HBM AXI port.
- Holds back all address handshakes until HBM calibration completes, then a fixed settle delay has elapsed.
- Caps outstanding reads and writes, and spaces out address issue while the DRAM temperature is high.
- On a catastrophic-temperature trip, blocks new traffic, drains in-flight transactions, then halts until reset.

Parameters:
- MAX_OUTSTANDING, 8, max in-flight transactions per direction (AR and AW counted separately), >=1.
- INIT_DELAY, 16, cycles to wait after apb_complete_i rises before traffic is enabled, >=1.
- TEMP_HI, 7'd85, temp_i value at or above which throttling starts.
- TEMP_LO, 7'd80, temp_i value below which throttling stops; must be < TEMP_HI.
- THROTTLE_GAP, 4, idle cycles forced after each accepted address while throttling, >=1.
- CW, $clog2(MAX_OUTSTANDING+1), outstanding-counter width (derived, not overridable).

Ports:
- clk  in  1  single clock for the block.
- rst_n  in  1  asynchronous active-low reset.
- apb_complete_i  in  1  HBM calibration done; level input, sampled only in INIT.
- cattrip_i  in  1  HBM catastrophic temperature trip.
- temp_i  in  7  HBM DRAM temperature.
- slv_ar_valid_i / slv_ar_ready_o  in/out  1/1  upstream read address handshake.
- mst_ar_valid_o / mst_ar_ready_i  out/in  1/1  HBM read address handshake.
- slv_aw_valid_i / slv_aw_ready_o  in/out  1/1  upstream write address handshake.
- mst_aw_valid_o / mst_aw_ready_i  out/in  1/1  HBM write address handshake.
- r_valid_i, r_ready_i, r_last_i  in  1 each  R channel, observed only.
- b_valid_i, b_ready_i  in  1 each  B channel, observed only.
- hbm_ready_o  out  1  state is RUN or THROTTLE.
- throttle_o  out  1  state is THROTTLE.
- halted_o  out  1  state is HALT.
- err_o  out  1  sticky; set on counter underflow.
- rd_outstanding_o  out  CW  in-flight read count.
- wr_outstanding_o  out  CW  in-flight write count.

Behaviour:
- Reset (async, rst_n=0):
  - state=INIT, delay counter=0, gap counter=0, both outstanding counters=0, err_o=0.
  - All registered outputs 0; gated valids/readies 0.
- Gating (combinational from registered state/counters; no added latency):
  - allow_ar = (state in RUN,THROTTLE) & rd_cnt<MAX_OUTSTANDING & gap==0.
  - mst_ar_valid_o = slv_ar_valid_i & allow_ar; slv_ar_ready_o = mst_ar_ready_i & allow_ar.
  - AW is identical, using wr_cnt.
  - W, R and B pass outside this block and are never gated.
- FSM:
  - INIT:
    - apb_complete_i=1 -> load delay=INIT_DELAY-1 and go to SETTLE.
    - cattrip_i=1 -> HALT; this takes priority over apb_complete_i.
  - SETTLE:
    - Decrement delay each cycle; at 0 -> RUN. Traffic is enabled INIT_DELAY cycles after the SETTLE entry edge.
    - cattrip_i=1 -> HALT.
  - RUN:
    - temp_i>=TEMP_HI -> THROTTLE.
    - cattrip_i=1 -> DRAIN; takes priority over the temperature transition.
  - THROTTLE:
    - temp_i<TEMP_LO -> RUN.
    - cattrip_i=1 -> DRAIN.
  - DRAIN:
    - No new addresses accepted.
    - rd_cnt==0 & wr_cnt==0 -> HALT. Counters still track R/B completions.
  - HALT: terminal; left only by reset.
  - apb_complete_i falling after INIT is ignored.
- Gap counter:
  - Any AR or AW handshake in THROTTLE loads gap=THROTTLE_GAP.
  - An AR and an AW accepted in the same cycle are both legal and cause a single reload.
  - gap decrements to 0 otherwise.
  - On THROTTLE->RUN, gap is cleared.
- Outstanding counters:
  - rd_cnt: +1 on AR handshake; -1 on r_valid_i & r_ready_i & r_last_i. Both in one cycle -> unchanged.
  - wr_cnt: +1 on AW handshake; -1 on b_valid_i & b_ready_i.
  - Decrement at 0: hold 0 and set err_o. err_o is cleared only by reset.
  - Increment is impossible at MAX_OUTSTANDING because of the gating.
- Reset mid-operation: everything returns to INIT immediately. In-flight HBM transactions are not tracked after reset.

Test Plan:
- Init sequence: apb_complete_i rises at cycle 10 with INIT_DELAY=16. Slave AR valid held high -> no mst_ar_valid_o before cycle 27; first handshake at cycle 27 when mst_ar_ready_i=1; hbm_ready_o=1 from cycle 27.
- Outstanding cap: 9 AR back-to-back with no R beats -> 8 accepted, rd_outstanding_o=8, slv_ar_ready_o=0. One R beat with r_last_i -> count 7 next cycle, 9th AR accepted the cycle after.
- Simultaneous events: AR handshake and R-last handshake in the same cycle -> rd_outstanding_o unchanged. B handshake at wr_cnt=0 -> wr_outstanding_o stays 0 and err_o=1 from the next cycle, sticky.
- Throttle hysteresis: temp_i=85 -> throttle_o=1; continuous AR requests are accepted only every 5th cycle (THROTTLE_GAP=4). temp_i=82 -> still throttled. temp_i=79 -> RUN, back-to-back acceptance.
- Trip with traffic in flight: 3 reads and 2 writes outstanding, cattrip_i=1 -> no further AR/AW accepted. After 3 R-last and 2 B handshakes, halted_o=1 on the next cycle. Deasserting cattrip_i does not leave HALT.
- Reset mid-DRAIN: rst_n low for 1 cycle -> all counters 0, state INIT, halted_o=0, err_o=0, and gating is closed until the init sequence repeats.
